// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared constants and types for the sprite pixel fetch path.
// Optional build macro: SPRITE_HIT_CNT_EN (sprite hit counter).
package sprite_pixel_fetch_pkg;

  localparam int unsigned SPR_COLOR_W         = 9;
  localparam int unsigned SPR_ADDR_W          = 10;
  localparam int unsigned SPR_ELEMENT_BARRIER = 5;
  localparam int unsigned SPR_NUM_ELEMENTS    = 31;
  localparam int unsigned SPR_HIT_CNT_W       = 20;

  localparam logic [SPR_COLOR_W-1:0] SPR_TRANSP_KEY = 9'h1FF;
  localparam logic [SPR_COLOR_W-1:0] SPR_BG_DEFAULT = 9'h000;

  // Request metadata that travels alongside the memory read.
  typedef struct packed {
    logic hit;
    logic active;
  } pix_meta_t;

  function automatic logic [SPR_HIT_CNT_W-1:0] sat_inc(
    input logic [SPR_HIT_CNT_W-1:0] v,
    input logic                     en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Request, sprite-memory and pixel-output bundle of the sprite pixel fetch block.
interface sprite_pixel_fetch_if
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int unsigned ELEMENT = SPR_ELEMENT_BARRIER,
  parameter int unsigned COLOR_W = SPR_COLOR_W
);

  logic                          active;
  logic                          ready;
  logic [ELEMENT-1:0]            element;
  logic [SPR_ADDR_W-1:0]         address;
  logic                          mem_rd;
  logic [ELEMENT+SPR_ADDR_W-1:0] mem_addr;
  logic [COLOR_W-1:0]            mem_data;
  logic [COLOR_W-1:0]            rgb;
  logic                          rgb_valid;

  // Selection logic / memory / DAC side.
  modport master (
    output active, ready, element, address, mem_data,
    input  mem_rd, mem_addr, rgb, rgb_valid
  );

  // Fetch block side.
  modport slave (
    input  active, ready, element, address, mem_data,
    output mem_rd, mem_addr, rgb, rgb_valid
  );

endinterface

// File: rtl/sprite_pixel_fetch_pixel_delay_line.sv
// MEM_LAT-deep shift register of {hit, active} with synchronous clear.
module pixel_delay_line
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      clr,
  input  pix_meta_t d,
  output pix_meta_t q
);

  pix_meta_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: issues sprite memory reads, aligns returned colour with VGA timing,
// applies transparency/background. Optional macro SPRITE_HIT_CNT_EN adds hit_count.
module sprite_pixel_fetch
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int unsigned          ELEMENT      = SPR_ELEMENT_BARRIER,
  parameter int unsigned          NUM_ELEMENTS = SPR_NUM_ELEMENTS,
  parameter int unsigned          COLOR_W      = SPR_COLOR_W,
  parameter int unsigned          MEM_LAT      = 1,
  parameter logic [COLOR_W-1:0]   TRANSP_KEY   = SPR_TRANSP_KEY,
  parameter logic [COLOR_W-1:0]   BG_DEFAULT   = SPR_BG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  sprite_pixel_fetch_if.slave       bus,
  input  logic                      bg_we,
  input  logic [COLOR_W-1:0]        bg_color_in,
  input  logic                      frame_end
`ifdef SPRITE_HIT_CNT_EN
  ,
  output logic [SPR_HIT_CNT_W-1:0]  hit_count
`endif
);

  localparam logic [ELEMENT:0] NUM_EL = NUM_ELEMENTS[ELEMENT:0];

  logic                          hit_c;
  logic                          rd_q;
  logic                          act_q;
  logic [ELEMENT+SPR_ADDR_W-1:0] addr_q;
  pix_meta_t                     meta_d;
  logic [COLOR_W-1:0]            bg_color;
  logic                          show_sprite;
  logic [COLOR_W-1:0]            rgb_n;
  logic                          vld_n;
  logic [COLOR_W-1:0]            rgb_q;
  logic                          vld_q;

  assign hit_c = bus.ready & bus.active & ({1'b0, bus.element} < NUM_EL);

  // Request stage: the address only moves on an actual read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= 1'b0;
      act_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      rd_q  <= hit_c;
      act_q <= bus.active;
      if (hit_c) begin
        addr_q <= {bus.element, bus.address};
      end
    end
  end

  assign bus.mem_rd   = rd_q;
  assign bus.mem_addr = addr_q;

  pixel_delay_line #(
    .DEPTH (MEM_LAT)
  ) u_delay (
    .clk (clk),
    .clr (reset),
    .d   ('{hit: rd_q, active: act_q}),
    .q   (meta_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bg_color <= BG_DEFAULT;
    end else if (bg_we) begin
      bg_color <= bg_color_in;
    end
  end

  // Resolve the pixel whose read data is on mem_data this cycle.
  always_comb begin
    show_sprite = meta_d.active & meta_d.hit & (bus.mem_data != TRANSP_KEY);
    rgb_n       = '0;
    vld_n       = 1'b0;
    if (meta_d.active) begin
      vld_n = 1'b1;
      rgb_n = show_sprite ? bus.mem_data : bg_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      vld_q <= 1'b0;
    end else begin
      rgb_q <= rgb_n;
      vld_q <= vld_n;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.rgb_valid = vld_q;

`ifdef SPRITE_HIT_CNT_EN
  logic [SPR_HIT_CNT_W-1:0] hit_cnt;

  // A hit landing on the frame_end cycle is folded into the latched value.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt   <= '0;
      hit_count <= '0;
    end else if (frame_end) begin
      hit_count <= sat_inc(hit_cnt, show_sprite);
      hit_cnt   <= '0;
    end else begin
      hit_cnt <= sat_inc(hit_cnt, show_sprite);
    end
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: doc/sprite_pixel_fetch.md
Name: sprite_pixel_fetch

Overview:
- Consumer end of the sprite-request interface. It takes the per-pixel (ready, element, address) request stream from the sprite-selection logic and issues reads to the synchronous sprite memory.
- Aligns the returned colour word with the VGA timing. Applies transparency and background colour, and drives the final RGB pixel to the VGA output stage.
- Sits between the sprite-selection logic and the VGA DAC pins, in the pixel clock domain.

Parameters:
- ELEMENT, 5, width of the element index (sprite slot number).
- NUM_ELEMENTS, 31, number of valid sprite slots. Element values >= NUM_ELEMENTS are invalid.
- COLOR_W, 9, width of the colour word (3 bits each for R, G, B).
- MEM_LAT, 1, sprite memory read latency in cycles (legal values 1..3).
- TRANSP_KEY, 9'h1FF, colour word treated as transparent.
- BG_DEFAULT, 9'h000, background colour loaded at reset.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- active  in  1  VGA visible-area flag for the current pixel.
- ready  in  1  a sprite covers the current pixel.
- element  in  ELEMENT  sprite slot of the current pixel.
- address  in  10  texel offset within the slot (32x32 sprite).
- mem_rd  out  1  sprite memory read strobe.
- mem_addr  out  ELEMENT+10  memory address, equal to {element, address}.
- mem_data  in  COLOR_W  read data, valid MEM_LAT cycles after mem_rd.
- bg_we  in  1  background colour write strobe.
- bg_color_in  in  COLOR_W  new background colour.
- frame_end  in  1  one-cycle pulse at the end of the visible frame.
- rgb  out  COLOR_W  pixel colour to the DAC.
- rgb_valid  out  1  rgb belongs to a visible pixel.

Behaviour:
- Reset (synchronous, active-high):
  - rgb=0, rgb_valid=0, mem_rd=0, mem_addr=0.
  - All pipeline stages cleared; bg_color=BG_DEFAULT.
- Request stage (cycle 0):
  - mem_rd and mem_addr are registered from the inputs sampled at cycle 0.
  - mem_rd = ready & active & (element < NUM_ELEMENTS).
  - mem_addr = {element, address} when mem_rd=1, else holds its previous value.
- Delay line: a shift register of depth MEM_LAT carries {hit, active}, where hit is the same term as mem_rd. This keeps the request metadata aligned with mem_data.
- Output stage:
  - Registered. Total latency from input to rgb is MEM_LAT+2 cycles, constant regardless of hit or miss.
  - active_d=0: rgb=0, rgb_valid=0 (blanking; never drive colour outside the visible area).
  - active_d=1 and hit_d=1 and mem_data != TRANSP_KEY: rgb=mem_data, rgb_valid=1.
  - Otherwise: rgb=bg_color, rgb_valid=1.
- Background register:
  - bg_we loads bg_color_in at the clock edge.
  - A pixel resolved in the same cycle as bg_we uses the old value.
- Pipeline behaviour:
  - One pixel per clock, no stalls, no backpressure.
  - Consecutive requests to the same address are issued again, with no caching.
- Invalid element (>= NUM_ELEMENTS): no memory read is issued; the pixel shows the background.
- Reset asserted mid-line: all in-flight pixels are dropped. rgb=0 from the cycle after the reset edge until new pixels traverse the full latency.
- frame_end: has no effect on colour. It is used only by the optional feature.

Optional Feature:
- Macro SPRITE_HIT_CNT_EN.
- Defined:
  - Adds output hit_count [19:0].
  - An internal counter increments on every output-stage pixel that shows sprite colour (not background, not transparent). It saturates at 20'hFFFFF.
  - On frame_end, hit_count latches the counter value (including a hit in that same cycle) and the counter clears to 0.
  - Reset clears both counter and hit_count.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the COLOR_W and TRANSP_KEY constants;
  - the 10-bit sprite address width;
  - the element-index constants used by the selection logic (barrier = 5).
- One natural sub-module: pixel_delay_line, a parameterised MEM_LAT-deep shift register of {hit, active} with synchronous clear.

Test Plan:
- Reset, then active=1 and ready=0 for 4 pixels -> mem_rd=0; rgb=9'h000 with rgb_valid=1 at cycle MEM_LAT+2 after each pixel.
- ready=1, element=5, address=10'd37; memory model returns 9'h1C0 -> mem_addr={5'd5,10'd37}, mem_rd=1 the cycle after input; rgb=9'h1C0 exactly MEM_LAT+2 cycles after input.
- Same request with the memory returning 9'h1FF, and bg set to 9'h038 via bg_we earlier -> rgb=9'h038.
- element=31 with ready=1 -> mem_rd=0; rgb=background.
- active=0 with ready=1 -> mem_rd=0, rgb=0, rgb_valid=0.
- Streaming 8 hits, reset asserted on the 4th -> rgb=0 from the cycle after the reset edge; no stale colour appears; the pipeline refills correctly.
- With SPRITE_HIT_CNT_EN defined: 100 sprite pixels including 10 transparent, then frame_end -> hit_count=90 and counter cleared; the next frame counts from 0.
